// File: rtl/fdiv_wb_tracker.sv
// Writeback tracker for the fixed-latency fdiv pipeline: tags issues in a shift register,
// queues results with their tags, and keeps a busy scoreboard plus credit-based issue throttling.
module fdiv_wb_tracker #(
    parameter int unsigned NSTAGE = 7,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAGW   = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 issue_valid,
    input  logic [TAGW-1:0]      issue_tag,
    output logic                 issue_ready,
    input  logic [TAGW-1:0]      src1_tag,
    input  logic [TAGW-1:0]      src2_tag,
    output logic                 hazard,
    input  logic [31:0]          res_data,
    output logic                 wb_valid,
    output logic [TAGW-1:0]      wb_tag,
    output logic [31:0]          wb_data,
    input  logic                 wb_ready,
    output logic [2**TAGW-1:0]   busy
);

    localparam int unsigned NREG = 2**TAGW;
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    // Issue-side shift register
    logic [NSTAGE-1:0] pipe_v_q;
    logic [TAGW-1:0]   pipe_tag_q [NSTAGE];

    // Result FIFO
    logic [TAGW-1:0]   mem_tag  [DEPTH];
    logic [31:0]       mem_data [DEPTH];
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;

    // Credits and scoreboard
    logic [CNTW-1:0]   inflight_q, inflight_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              acc;
    logic              arr_v;
    logic [TAGW-1:0]   arr_tag;
    logic              push;
    logic              pop;
    logic [CNTW:0]     credit_used;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // Pop frees a slot only once count_q updates, so there is no same-cycle credit return.
    assign credit_used = (CNTW+1)'(inflight_q) + (CNTW+1)'(count_q);
    assign issue_ready = (credit_used < (CNTW+1)'(DEPTH)) & ~busy_q[issue_tag];
    assign acc         = issue_valid & issue_ready;

    assign arr_v   = pipe_v_q[NSTAGE-1];
    assign arr_tag = pipe_tag_q[NSTAGE-1];

    assign wb_valid = (count_q != '0);
    assign wb_tag   = wb_valid ? mem_tag[rd_ptr_q]  : '0;
    assign wb_data  = wb_valid ? mem_data[rd_ptr_q] : '0;

    assign push = arr_v;
    assign pop  = wb_valid & wb_ready;

    assign hazard = busy_q[src1_tag] | busy_q[src2_tag];
    assign busy   = busy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_v_q <= '0;
        end else begin
            pipe_v_q[0] <= acc;
            for (int k = 1; k < NSTAGE; k++) begin
                pipe_v_q[k] <= pipe_v_q[k-1];
            end
        end
    end

    // Tags are qualified by pipe_v_q, so they need no reset.
    always_ff @(posedge clk) begin
        pipe_tag_q[0] <= issue_tag;
        for (int k = 1; k < NSTAGE; k++) begin
            pipe_tag_q[k] <= pipe_tag_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_tag[wr_ptr_q]  <= arr_tag;
            mem_data[wr_ptr_q] <= res_data;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        unique case ({acc, arr_v})
            2'b10:   inflight_d = inflight_q + CNTW'(1);
            2'b01:   inflight_d = inflight_q - CNTW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Clear before set so a same-cycle set on the same tag wins.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[wb_tag] = 1'b0;
        end
        if (acc && (issue_tag != '0)) begin
            busy_d[issue_tag] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            busy_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_fdiv_wb_tracker.sv
// Directed bench for fdiv_wb_tracker: latency, streaming, credits, hazards, FIFO wrap and
// async reset, with hand-computed expectations and a small queue model for the stream.
module tb_fdiv_wb_tracker;

    localparam int NSTAGE = 7;
    localparam int DEPTH  = 8;
    localparam int TAGW   = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic            issue_valid;
    logic [TAGW-1:0] issue_tag;
    logic            issue_ready;
    logic [TAGW-1:0] src1_tag;
    logic [TAGW-1:0] src2_tag;
    logic            hazard;
    logic [31:0]     res_data;
    logic            wb_valid;
    logic [TAGW-1:0] wb_tag;
    logic [31:0]     wb_data;
    logic            wb_ready;
    logic [31:0]     busy;

    int ncmp  = 0;
    int nfail = 0;
    logic ovf_seen = 1'b0;

    fdiv_wb_tracker #(
        .NSTAGE (NSTAGE),
        .DEPTH  (DEPTH),
        .TAGW   (TAGW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .src1_tag    (src1_tag),
        .src2_tag    (src2_tag),
        .hazard      (hazard),
        .res_data    (res_data),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // A push into a full FIFO must never happen.
    always @(posedge clk) begin
        if (rstn && dut.pipe_v_q[NSTAGE-1] && (32'(dut.count_q) == DEPTH)) ovf_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [TAGW-1:0] fq_tag[$];
    logic [31:0]     fq_data[$];
    int              pend_idx[$];
    int              pend_cyc[$];

    initial begin
        int  n_iss;
        int  n_pop;
        int  hidx;
        bit  hv;
        bit  arrive;
        bit  exp_ready;

        rstn        = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = '0;
        src1_tag    = '0;
        src2_tag    = '0;
        res_data    = '0;
        wb_ready    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wbv",   32'(wb_valid),    32'd0);
        chk("rst_wbtag", 32'(wb_tag),      32'd0);
        chk("rst_wbdat", wb_data,          32'd0);
        chk("rst_busy",  busy,             32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_haz",   32'(hazard),      32'd0);
        #2 rstn = 1'b1;

        // Single issue: tag 3 at cycle 0, result at cycle 7, writeback in cycle 8
        tick();
        issue_valid = 1'b1; issue_tag = 5'd3; wb_ready = 1'b1; res_data = 32'hdead_0000;
        #1;
        chk("t1_ready", 32'(issue_ready), 32'd1);
        for (int c = 1; c <= 9; c++) begin
            tick();
            issue_valid = 1'b0; issue_tag = '0;
            res_data = (c == 7) ? 32'h4000_0000 : 32'hdead_0000 + 32'(c);
            #1;
            chk("t1_wbv",   32'(wb_valid), 32'(c == 8));
            chk("t1_wbtag", 32'(wb_tag),   (c == 8) ? 32'd3 : 32'd0);
            chk("t1_wbdat", wb_data,       (c == 8) ? 32'h4000_0000 : 32'd0);
            chk("t1_busy3", 32'(busy[3]),  32'(c <= 8));
        end

        // Back-to-back: tags 1..8 at cycles 0..7, writebacks at cycles 8..15
        for (int c = 0; c <= 16; c++) begin
            tick();
            issue_valid = (c < 8);
            issue_tag   = (c < 8) ? TAGW'(c + 1) : '0;
            res_data    = (c >= 7 && c <= 14) ? 32'h3f80_0000 + 32'(c - 6) : 32'hbad0_0000 + 32'(c);
            wb_ready    = 1'b1;
            #1;
            hv = (c >= 8 && c <= 15);
            if (c < 8) chk("t2_ready", 32'(issue_ready), 32'd1);
            chk("t2_wbv",   32'(wb_valid), 32'(hv));
            chk("t2_wbtag", 32'(wb_tag),   hv ? 32'(c - 7) : 32'd0);
            chk("t2_wbdat", wb_data,       hv ? 32'h3f80_0000 + 32'(c - 7) : 32'd0);
        end

        // Stall/credit: wb_ready low, 8 accepts fill the credits, 9th is ignored
        for (int c = 0; c <= 24; c++) begin
            tick();
            wb_ready    = (c >= 16);
            issue_valid = (c <= 8);
            issue_tag   = (c <= 8) ? TAGW'(10 + c) : '0;
            res_data    = (c >= 7 && c <= 14) ? 32'hc0de_0000 + 32'(c - 7) : 32'h0bad_0000 + 32'(c);
            #1;
            if (c <= 7)  chk("t3_ready",      32'(issue_ready), 32'd1);
            if (c == 8)  chk("t3_ready_9th",  32'(issue_ready), 32'd0);
            if (c == 8)  chk("t3_busy_set",   busy,             32'h0003_fc00);
            if (c == 9)  chk("t3_busy18",     32'(busy[18]),    32'd0);
            if (c == 16) chk("t3_ready_full", 32'(issue_ready), 32'd0);
            if (c == 17) chk("t3_ready_back", 32'(issue_ready), 32'd1);
            if (c == 24) chk("t3_busy_clr",   busy,             32'd0);
            hv   = (c >= 8 && c <= 23);
            hidx = (c < 16) ? 0 : c - 16;
            chk("t3_wbv",   32'(wb_valid), 32'(hv));
            chk("t3_wbtag", 32'(wb_tag),   hv ? 32'(10 + hidx) : 32'd0);
            chk("t3_wbdat", wb_data,       hv ? 32'hc0de_0000 + 32'(hidx) : 32'd0);
        end

        // Hazard / WAW / tag 0
        for (int c = 0; c <= 11; c++) begin
            tick();
            issue_valid = (c <= 2);
            issue_tag   = (c <= 1) ? 5'd5 : 5'd0;
            src1_tag    = (c <= 2) ? 5'd5 : 5'd0;
            src2_tag    = (c >= 4) ? 5'd5 : 5'd0;
            wb_ready    = 1'b1;
            res_data    = (c == 7) ? 32'h3f80_0000 :
                          (c == 9) ? 32'h1234_5678 : 32'h5555_0000 + 32'(c);
            #1;
            if (c == 0) chk("t4_ready_first", 32'(issue_ready), 32'd1);
            if (c == 1) chk("t4_ready_waw",   32'(issue_ready), 32'd0);
            if (c == 2) chk("t4_ready_tag0",  32'(issue_ready), 32'd1);
            if (c == 1 || c == 3) chk("t4_busy", busy, 32'h0000_0020);
            if (c >= 9) chk("t4_busy_clr", busy, 32'd0);
            chk("t4_hazard", 32'(hazard), 32'((c >= 1 && c <= 2) || (c >= 4 && c <= 8)));
            chk("t4_wbv",    32'(wb_valid), 32'(c == 8 || c == 10));
            chk("t4_wbtag",  32'(wb_tag), (c == 8) ? 32'd5 : 32'd0);
            chk("t4_wbdat",  wb_data, (c == 8) ? 32'h3f80_0000 :
                                      (c == 10) ? 32'h1234_5678 : 32'd0);
        end
        src1_tag = '0; src2_tag = '0;

        // Stream 28 results through the FIFO across several pointer wraps
        n_iss = 0;
        n_pop = 0;
        for (int c = 0; c < 200 && n_pop < 28; c++) begin
            tick();
            arrive      = (pend_cyc.size() > 0) && (pend_cyc[0] == c);
            wb_ready    = (c >= 15) && (c % 5 != 0);
            issue_valid = (n_iss < 28);
            issue_tag   = TAGW'(n_iss + 1);
            res_data    = arrive ? 32'ha5a5_0000 + 32'(pend_idx[0]) : 32'hffff_0000 + 32'(c);
            #1;
            exp_ready = (pend_cyc.size() + fq_tag.size() < DEPTH);
            if (issue_valid) chk("t5_ready", 32'(issue_ready), 32'(exp_ready));
            chk("t5_wbv", 32'(wb_valid), 32'(fq_tag.size() > 0));
            if (fq_tag.size() > 0) begin
                chk("t5_wbtag", 32'(wb_tag), 32'(fq_tag[0]));
                chk("t5_wbdat", wb_data,     fq_data[0]);
                if (wb_ready) begin
                    void'(fq_tag.pop_front());
                    void'(fq_data.pop_front());
                    n_pop++;
                end
            end
            if (arrive) begin
                fq_tag.push_back(TAGW'(pend_idx[0] + 1));
                fq_data.push_back(32'ha5a5_0000 + 32'(pend_idx[0]));
                void'(pend_idx.pop_front());
                void'(pend_cyc.pop_front());
            end
            if (issue_valid && exp_ready) begin
                pend_idx.push_back(n_iss);
                pend_cyc.push_back(c + NSTAGE);
                n_iss++;
            end
        end
        chk("t5_popped", 32'(n_pop), 32'd28);
        issue_valid = 1'b0;
        issue_tag   = '0;
        repeat (3) tick();

        // Async reset with 2 queued and 3 in flight
        for (int c = 0; c <= 9; c++) begin
            tick();
            issue_valid = (c < 5);
            issue_tag   = (c < 5) ? TAGW'(c + 1) : '0;
            wb_ready    = 1'b0;
            res_data    = 32'h7700_0000 + 32'(c);
            #1;
            if (c < 5) chk("t6_ready", 32'(issue_ready), 32'd1);
        end
        chk("t6_pre_wbv",   32'(wb_valid), 32'd1);
        chk("t6_pre_wbtag", 32'(wb_tag),   32'd1);
        chk("t6_pre_busy",  busy,          32'h0000_003e);
        rstn = 1'b0;
        #1;
        chk("t6_rst_wbv",   32'(wb_valid),    32'd0);
        chk("t6_rst_busy",  busy,             32'd0);
        chk("t6_rst_wbtag", 32'(wb_tag),      32'd0);
        chk("t6_rst_wbdat", wb_data,          32'd0);
        chk("t6_rst_ready", 32'(issue_ready), 32'd1);
        tick();
        #2 rstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            issue_valid = 1'b0;
            wb_ready    = 1'b1;
            res_data    = $urandom;
            #1;
            chk("t6_post_wbv",  32'(wb_valid), 32'd0);
            chk("t6_post_busy", busy,          32'd0);
        end

        chk("no_overflow", 32'(ovf_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
